score_bcd_converter: RTL
========================

// Module: score_bcd_converter
// PURPOSE
//  Upstream feeder of the 7-segment display multiplexer.
//  Converts the two players' binary scores into decimal tens/ones nibbles, one nibble per display digit.
//  Uses a sequential double-dabble (shift/add-3) engine shared by both channels.
//  Both players' digits update atomically, so the display never shows a half-updated score pair.
// PARAMETERS
//  SCORE_W  7   width of each binary score input; shift cycles per channel = SCORE_W
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        synchronous reset, ACTIVE-LOW (rst==0 resets on next clk edge)
//  score_p1   in   SCORE_W  player 1 score, unsigned binary
//  score_p2   in   SCORE_W  player 2 score, unsigned binary
//  start      in   1        conversion request, sampled every edge
//  busy       out  1        1 while a conversion is in progress
//  done       out  1        1-cycle pulse; new digits valid from this cycle onward
//  p1_tens    out  4        player 1 tens digit, BCD 0..9
//  p1_ones    out  4        player 1 ones digit, BCD 0..9
//  p2_tens    out  4        player 2 tens digit, BCD 0..9
//  p2_ones    out  4        player 2 ones digit, BCD 0..9
// BEHAVIOUR
//  Reset (rst==0): state=IDLE; busy=0, done=0, pending=0; all four digits=0.
//   Reset takes priority over every other event.
//  FSM states: IDLE, SHIFT, COMMIT; channel bit ch (0=p1, 1=p2).
//  IDLE:
//   - On the edge with start==1: snapshot score_p1/score_p2, load p1 snapshot into the shift register.
//   - Clear the BCD accumulator; ch=0; go to SHIFT; busy=1.
//  SHIFT (exactly SCORE_W edges):
//   - Each edge: add 3 to any BCD nibble >=5, then shift left 1, taking the binary MSB in.
//   - After SCORE_W edges go to COMMIT.
//  COMMIT, ch=0: store p1 result internally; load p2 snapshot; clear the accumulator; ch=1; go to SHIFT.
//  COMMIT, ch=1:
//   - Write all four digit outputs on the same edge, from the internal p1 result and the p2 result.
//   - done=1 for the following cycle.
//   - If (start|pending): take a new snapshot, clear pending, ch=0, go to SHIFT with busy=1.
//   - Otherwise go to IDLE with busy=0.
//  Latency: start sampled on edge E0; digits update and done rises on edge E0+2*(SCORE_W+1)
//   (16 for default). Back-to-back throughput is one result per 2*(SCORE_W+1) cycles.
//  Accumulator: 3 nibbles (covers <=999, sufficient for SCORE_W<=9).
//  Saturation, per channel at COMMIT: if snapshot > 99, the result is forced to tens=9, ones=9.
//   The hundreds nibble is never output.
//  start while busy: not lost; sets pending, serviced at the final COMMIT. Multiple requests collapse into one.
//  Scores are read only at snapshot edges; input changes mid-conversion have no effect on the running result.
//  Digit outputs hold their last committed value between done pulses. Outputs are all registered.
//  start and done coincident at the final COMMIT: done still pulses; the new conversion starts seamlessly.
// TESTING (SCORE_W=7)
//  1. Reset: hold rst=0 for 3 clk with start=1 -> busy=0, done=0, all digits 0; no conversion after release
//     until start is sampled.
//  2. p1=42, p2=7, 1-cycle start -> busy=1 for 16 cycles; done pulses once at edge 16; digits 4,2,0,7;
//     done=0 afterwards, digits held.
//  3. Saturation/boundaries:
//     - p1=127, p2=100 -> 9,9,9,9.
//     - p1=99, p2=0 -> 9,9,0,0.
//     - p1=10, p2=9 -> 1,0,0,9.
//  4. Pending: start with p1=5, p2=6, then at cycle 4 set p1=30, p2=31 and pulse start
//     -> done at 16 with 0,5,0,6; busy stays 1; done at 32 with 3,0,3,1.
//  5. Reset mid-op: start p1=55, drive rst=0 at cycle 6 -> next edge busy=0, digits 0, no done pulse ever
//     for that request.
//  6. start held high continuously with p1=p2=12 -> done every 16 cycles, busy never drops, digits 1,2,1,2.

Source files
------------

// File: rtl/score_bcd_if.sv
// Handshake and data bundle between the score source, the BCD converter and the display mux.
// The master drives the scores and start; the slave returns status and the four BCD digits.
interface score_bcd_if #(
    parameter int SCORE_W = 7
);
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         p1_tens;
    logic [3:0]         p1_ones;
    logic [3:0]         p2_tens;
    logic [3:0]         p2_ones;

    modport master (
        output score_p1, score_p2, start,
        input  busy, done, p1_tens, p1_ones, p2_tens, p2_ones
    );

    modport slave (
        input  score_p1, score_p2, start,
        output busy, done, p1_tens, p1_ones, p2_tens, p2_ones
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Converts two binary scores to BCD tens/ones with one shared shift/add-3 engine.
// Both players' digits are written on the same edge, so the display never shows a mixed pair.
module score_bcd_converter #(
    parameter int SCORE_W = 7
) (
    input  logic          clk,
    input  logic          rst,
    score_bcd_if.slave    bus
);
    localparam int              CNT_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ch;
    logic               r_busy;
    logic               r_done;
    logic               r_pending;
    logic [15:0]        r_digits;
    logic [SCORE_W-1:0] r_snap1;
    logic [SCORE_W-1:0] r_snap2;
    logic [SCORE_W-1:0] r_sh;
    logic [11:0]        r_acc;
    logic [7:0]         r_p1_res;
    logic [11:0]        w_adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Scores above 99 cannot be shown on two digits, so they pin to 99.
    function automatic logic [7:0] sat_digits(input logic [SCORE_W-1:0] snap,
                                              input logic [11:0] acc);
        logic [31:0] wide;
        wide = 32'(snap);
        return (wide > 32'd99) ? 8'h99 : acc[7:0];
    endfunction

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 3; i++) begin
            w_adj[4*i +: 4] = add3(r_acc[4*i +: 4]);
        end
    end

    // Control path: FSM, status flags and the committed digit outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ch      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pending <= 1'b0;
            r_digits  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                        r_ch    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bus.start) r_pending <= 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_COMMIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (!r_ch) begin
                        if (bus.start) r_pending <= 1'b1;
                        r_ch    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_digits <= {r_p1_res, sat_digits(r_snap2, r_acc)};
                        r_done   <= 1'b1;
                        if (bus.start || r_pending) begin
                            r_pending <= 1'b0;
                            r_ch      <= 1'b0;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: snapshots, shift register and BCD accumulator; no reset needed.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    r_snap1 <= bus.score_p1;
                    r_snap2 <= bus.score_p2;
                    r_sh    <= bus.score_p1;
                    r_acc   <= '0;
                end
            end
            S_SHIFT: begin
                r_acc <= 12'({w_adj, r_sh[SCORE_W-1]});
                r_sh  <= r_sh << 1;
            end
            S_COMMIT: begin
                if (!r_ch) begin
                    r_p1_res <= sat_digits(r_snap1, r_acc);
                    r_sh     <= r_snap2;
                    r_acc    <= '0;
                end else if (bus.start || r_pending) begin
                    r_snap1 <= bus.score_p1;
                    r_snap2 <= bus.score_p2;
                    r_sh    <= bus.score_p1;
                    r_acc   <= '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.p1_tens = r_digits[15:12];
    assign bus.p1_ones = r_digits[11:8];
    assign bus.p2_tens = r_digits[7:4];
    assign bus.p2_ones = r_digits[3:0];
endmodule
